// File: rtl/fir_trigger_disc_if.sv
// Sample-word bus from the 4-lane FIR filter into the trigger discriminator.
interface fir_trigger_disc_if #(
  parameter int unsigned NBITS = 31
);
  logic               valid_in;
  logic [4*NBITS-1:0] in_data;

  modport master (output valid_in, output in_data);
  modport slave  (input  valid_in, input  in_data);
endinterface

// File: rtl/fir_trigger_disc.sv
// Upward threshold-crossing trigger with sample-level timestamp, holdoff and hysteresis re-arm.
// Optional peak capture over the trigger/holdoff window: define FIR_TRIG_PEAK_CAPTURE_EN.
module fir_trigger_disc #(
  parameter int unsigned NBITS        = 31,
  parameter int unsigned HOLDOFF_BITS = 16,
  parameter int unsigned TS_BITS      = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  fir_trigger_disc_if.slave        in_if,
  input  logic                     enable,
  input  logic signed [NBITS-1:0]  threshold,
  input  logic signed [NBITS-1:0]  rearm_level,
  input  logic [HOLDOFF_BITS-1:0]  holdoff,
  output logic                     trig_out,
  output logic [1:0]               trig_lane,
  output logic [TS_BITS+1:0]       trig_ts,
  output logic signed [NBITS-1:0]  trig_sample,
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
  output logic                     peak_valid,
  output logic signed [NBITS-1:0]  peak_value,
`endif
  output logic [1:0]               state_out
);

  localparam int unsigned NLANES = 4;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2,
    ST_REARM    = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [HOLDOFF_BITS-1:0]   cnt_q, cnt_d;
  logic [TS_BITS-1:0]        word_count_q, word_count_d;
  logic signed [NBITS-1:0]   prev_sample_q, prev_sample_d;
  logic                      prev_valid_q, prev_valid_d;
  logic                      trig_q, trig_d;
  logic [1:0]                trig_lane_q, trig_lane_d;
  logic [TS_BITS+1:0]        trig_ts_q, trig_ts_d;
  logic signed [NBITS-1:0]   trig_sample_q, trig_sample_d;

  logic signed [NBITS-1:0]   lane_c [NLANES];
  logic signed [NBITS-1:0]   left_c [NLANES];
  logic [NLANES-1:0]         cross_c;
  logic                      cross_found_c;
  logic [1:0]                cross_lane_c;
  logic                      all_below_c;

`ifdef FIR_TRIG_PEAK_CAPTURE_EN
  logic signed [NBITS-1:0]   peak_acc_q, peak_acc_d;
  logic                      peak_valid_q, peak_valid_d;
  logic signed [NBITS-1:0]   peak_value_q, peak_value_d;
  logic signed [NBITS-1:0]   tail_max_c [NLANES];
  logic signed [NBITS-1:0]   hold_max_c;
`endif

  always_comb begin : lane_split
    for (int k = 0; k < NLANES; k++) begin
      lane_c[k] = in_if.in_data[NBITS*k +: NBITS];
    end
  end

  // Each lane is compared with its left neighbour; lane 0's neighbour is lane 3 of the previous word.
  always_comb begin : crossing_detect
    left_c[0] = prev_sample_q;
    for (int k = 1; k < NLANES; k++) begin
      left_c[k] = lane_c[k-1];
    end
    all_below_c = 1'b1;
    for (int k = 0; k < NLANES; k++) begin
      cross_c[k] = (lane_c[k] > threshold) && (left_c[k] <= threshold);
      if (lane_c[k] >= rearm_level) all_below_c = 1'b0;
    end
    cross_c[0]    = cross_c[0] & prev_valid_q;
    cross_found_c = |cross_c;
    cross_lane_c  = '0;
    for (int k = NLANES - 1; k >= 0; k--) begin
      if (cross_c[k]) cross_lane_c = 2'(k);
    end
  end

`ifdef FIR_TRIG_PEAK_CAPTURE_EN
  // tail_max_c[k] is the maximum of lanes k..3 of the current word.
  always_comb begin : peak_tail
    tail_max_c[NLANES-1] = lane_c[NLANES-1];
    for (int k = NLANES - 2; k >= 0; k--) begin
      tail_max_c[k] = (lane_c[k] > tail_max_c[k+1]) ? lane_c[k] : tail_max_c[k+1];
    end
    hold_max_c = (peak_acc_q > tail_max_c[0]) ? peak_acc_q : tail_max_c[0];
  end
`endif

  always_comb begin : next_state
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_count_d  = word_count_q;
    prev_sample_d = prev_sample_q;
    prev_valid_d  = prev_valid_q;
    trig_d        = 1'b0;
    trig_lane_d   = trig_lane_q;
    trig_ts_d     = trig_ts_q;
    trig_sample_d = trig_sample_q;
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
    peak_acc_d    = peak_acc_q;
    peak_valid_d  = 1'b0;
    peak_value_d  = peak_value_q;
`endif

    if (in_if.valid_in) begin
      word_count_d  = word_count_q + TS_BITS'(1);
      prev_sample_d = lane_c[NLANES-1];
      prev_valid_d  = 1'b1;
    end

    if (!enable) begin
      state_d = ST_DISABLED;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_DISABLED: state_d = ST_ARMED;
        ST_ARMED: begin
          if (in_if.valid_in && cross_found_c) begin
            trig_d        = 1'b1;
            trig_lane_d   = cross_lane_c;
            trig_ts_d     = {word_count_q, cross_lane_c};
            trig_sample_d = lane_c[cross_lane_c];
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
            peak_acc_d    = tail_max_c[cross_lane_c];
            if (holdoff == '0) begin
              peak_valid_d = 1'b1;
              peak_value_d = tail_max_c[cross_lane_c];
            end
`endif
            if (holdoff == '0) begin
              state_d = ST_REARM;
            end else begin
              state_d = ST_HOLDOFF;
              cnt_d   = holdoff;
            end
          end
        end
        ST_HOLDOFF: begin
          if (in_if.valid_in) begin
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
            peak_acc_d = hold_max_c;
`endif
            if (cnt_q <= HOLDOFF_BITS'(1)) begin
              state_d = ST_REARM;
              cnt_d   = '0;
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
              peak_valid_d = 1'b1;
              peak_value_d = hold_max_c;
`endif
            end else begin
              cnt_d = cnt_q - HOLDOFF_BITS'(1);
            end
          end
        end
        ST_REARM: begin
          if (in_if.valid_in && all_below_c) state_d = ST_ARMED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!reset_n) begin
      state_q       <= ST_DISABLED;
      cnt_q         <= '0;
      word_count_q  <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      trig_q        <= 1'b0;
      trig_lane_q   <= '0;
      trig_ts_q     <= '0;
      trig_sample_q <= '0;
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
      peak_acc_q    <= '0;
      peak_valid_q  <= 1'b0;
      peak_value_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_count_q  <= word_count_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      trig_q        <= trig_d;
      trig_lane_q   <= trig_lane_d;
      trig_ts_q     <= trig_ts_d;
      trig_sample_q <= trig_sample_d;
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
      peak_acc_q    <= peak_acc_d;
      peak_valid_q  <= peak_valid_d;
      peak_value_q  <= peak_value_d;
`endif
    end
  end

  assign trig_out    = trig_q;
  assign trig_lane   = trig_lane_q;
  assign trig_ts     = trig_ts_q;
  assign trig_sample = trig_sample_q;
  assign state_out   = state_q;
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
  assign peak_valid  = peak_valid_q;
  assign peak_value  = peak_value_q;
`endif

endmodule

// File: tb/tb_fir_trigger_disc.sv
// Scoreboard bench for fir_trigger_disc: directed scenarios then randomized traffic against a word-level model.
module tb_fir_trigger_disc;
  localparam int unsigned NBITS = 31;
  localparam int unsigned HB    = 16;
  localparam int unsigned TSB   = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n;
  logic                    enable;
  logic signed [NBITS-1:0] threshold;
  logic signed [NBITS-1:0] rearm_level;
  logic [HB-1:0]           holdoff;
  logic                    trig_out;
  logic [1:0]              trig_lane;
  logic [TSB+1:0]          trig_ts;
  logic signed [NBITS-1:0] trig_sample;
  logic [1:0]              state_out;
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
  logic                    peak_valid;
  logic signed [NBITS-1:0] peak_value;
`endif

  fir_trigger_disc_if #(.NBITS(NBITS)) bus ();

  fir_trigger_disc #(.NBITS(NBITS), .HOLDOFF_BITS(HB), .TS_BITS(TSB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_if       (bus),
    .enable      (enable),
    .threshold   (threshold),
    .rearm_level (rearm_level),
    .holdoff     (holdoff),
    .trig_out    (trig_out),
    .trig_lane   (trig_lane),
    .trig_ts     (trig_ts),
    .trig_sample (trig_sample),
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
    .peak_valid  (peak_valid),
    .peak_value  (peak_value),
`endif
    .state_out   (state_out)
  );

  typedef struct { int st; bit trg; bit zchk; } cyc_t;
  typedef struct { int lane; longint ts; int sample; } trg_t;

  cyc_t   cyc_q[$];
  trg_t   exp_trg_q[$];
  int     exp_pk_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;

  // Test-controlled live settings
  int th = 100, rl = 50, ho = 3;

  // Reference model state (mode: 0 disabled, 1 armed, 2 holdoff, 3 rearm)
  int     m_mode = 0, m_cnt = 0, m_prev = 0, m_acc = 0;
  bit     m_pv = 0;
  longint m_wc = 0;
  localparam longint WC_MASK = (64'sd1 <<< TSB) - 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int max4(input int w[4], input int from);
    int m = w[from];
    for (int k = from + 1; k < 4; k++) if (w[k] > m) m = w[k];
    return m;
  endfunction

  // Word-level behavioural model: what the design does at the coming clock edge.
  task automatic model_step(input bit rst, input bit en, input bit vld, input int w[4], output bit trg);
    int hit = -1;
    trg = 1'b0;
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_prev = 0; m_pv = 0; m_wc = 0; m_acc = 0;
      return;
    end
    if (!en) begin
      m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (vld) begin
      if (m_mode == 1) begin
        for (int k = 0; k < 4 && hit < 0; k++) begin
          int  p  = (k == 0) ? m_prev : w[(k == 0) ? 0 : k - 1];
          bit  ok = (k == 0) ? m_pv : 1'b1;
          if (ok && w[k] > th && p <= th) hit = k;
        end
        if (hit >= 0) begin
          trg = 1'b1;
          exp_trg_q.push_back('{lane: hit, ts: (m_wc << 2) | longint'(hit), sample: w[hit]});
          m_acc = max4(w, hit);
          if (ho == 0) begin
            m_mode = 3;
            exp_pk_q.push_back(m_acc);
          end else begin
            m_mode = 2; m_cnt = ho;
          end
        end
      end else if (m_mode == 2) begin
        if (max4(w, 0) > m_acc) m_acc = max4(w, 0);
        if (m_cnt == 1) begin
          m_mode = 3; m_cnt = 0;
          exp_pk_q.push_back(m_acc);
        end else begin
          m_cnt--;
        end
      end else begin
        if (max4(w, 0) < rl) m_mode = 1;
      end
    end
    if (vld) begin
      m_wc   = (m_wc + 1) & WC_MASK;
      m_prev = w[3];
      m_pv   = 1'b1;
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit vld,
                       input int a, input int b, input int c, input int d);
    int   w[4];
    bit   trg;
    cyc_t e;
    @(negedge clk);
    w = '{a, b, c, d};
    reset_n      = rst;
    enable       = en;
    threshold    = NBITS'(th);
    rearm_level  = NBITS'(rl);
    holdoff      = HB'(ho);
    bus.valid_in = vld;
    for (int k = 0; k < 4; k++) bus.in_data[NBITS*k +: NBITS] = NBITS'(w[k]);
    model_step(rst, en, vld, w, trg);
    e.st = m_mode; e.trg = trg; e.zchk = !rst;
    cyc_q.push_back(e);
  endtask

  task automatic wd(input int a, input int b, input int c, input int d);
    drive(1'b1, 1'b1, 1'b1, a, b, c, d);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_sample();
    int unsigned r = $urandom_range(0, 19);
    if (r == 0) return -(2 ** 30);
    if (r == 1) return (2 ** 30) - 1;
    return int'($urandom_range(0, 260)) - 60;
  endfunction

  // Monitor: checks each cycle's state/pulse and pops payloads when the DUT presents them.
  initial begin
    cyc_t c;
    trg_t t;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("state_out", longint'(state_out), longint'(c.st));
        chk("trig_out", longint'(trig_out), longint'(c.trg));
        if (c.zchk) begin
          chk("rst_trig_lane", longint'(trig_lane), 0);
          chk("rst_trig_ts", longint'(trig_ts), 0);
          chk("rst_trig_sample", longint'(trig_sample), 0);
        end
      end
      if (trig_out) begin
        if (exp_trg_q.size() == 0) begin
          chk("unexpected_trigger", 1, 0);
        end else begin
          t = exp_trg_q.pop_front();
          chk("trig_lane", longint'(trig_lane), longint'(t.lane));
          chk("trig_ts", longint'(trig_ts), t.ts);
          chk("trig_sample", longint'(trig_sample), longint'(t.sample));
        end
      end
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
      if (peak_valid) begin
        if (exp_pk_q.size() == 0) chk("unexpected_peak", 1, 0);
        else chk("peak_value", longint'(peak_value), longint'(exp_pk_q.pop_front()));
      end
`endif
    end
  end

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    threshold    = NBITS'(th);
    rearm_level  = NBITS'(rl);
    holdoff      = HB'(ho);
    bus.valid_in = 1'b0;
    bus.in_data  = '0;

    // Reset and single in-word crossing
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    idle();
    wd(0, 0, 0, 0);
    wd(0, 0, 150, 200);
    // Holdoff then hysteresis re-arm, then a lane-3 trigger
    repeat (3) wd(200, 200, 200, 200);
    repeat (2) wd(60, 60, 60, 60);
    wd(40, 40, 40, 40);
    wd(40, 40, 40, 150);

    // Crossing across a word boundary with gaps
    drive(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    idle();
    wd(0, 0, 0, 90);
    idle();
    idle();
    wd(120, 0, 0, 0);

    // Multiple crossings in one word with zero holdoff
    ho = 0;
    repeat (3) wd(0, 0, 0, 0);
    wd(0, 0, 0, 0);
    wd(0, 150, 0, 150);
    wd(0, 0, 0, 0);

    // Enable drops in the same cycle as a crossing word
    drive(1'b1, 1'b0, 1'b1, 0, 150, 0, 0);

    // Peak window: trigger word then holdoff words
    ho = 3;
    idle();
    wd(0, 150, 300, 120);
    wd(250, 0, 0, 0);
    wd(10, 10, 10, 10);
    wd(0, 0, 0, 0);

    // Reset in the middle of holdoff
    wd(0, 0, 0, 0);
    wd(0, 0, 0, 150);
    wd(200, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 200, 200, 200, 200);
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst, en, vld;
      if ($urandom_range(0, 49) == 0) ho = int'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) begin
        th = int'($urandom_range(0, 150)) - 20;
        rl = th - int'($urandom_range(0, 80));
      end
      rst = ($urandom_range(0, 299) != 0);
      en  = ($urandom_range(0, 39) != 0);
      vld = ($urandom_range(0, 9) < 7);
      drive(rst, en, vld, rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
    end
    repeat (4) idle();

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("cycle_queue_drained", longint'(cyc_q.size()), 0);
    chk("trigger_queue_drained", longint'(exp_trg_q.size()), 0);
`ifdef FIR_TRIG_PEAK_CAPTURE_EN
    chk("peak_queue_drained", longint'(exp_pk_q.size()), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
